// File: rtl/core_dmem_responder.sv
// core_dmem_responder: dmem request/grant responder backed by a 64-bit word SRAM
//
// Accepts one request at a time from the LSU, waits WAIT_CYCLES, then pulses
// dmem_gnt for one cycle with dmem_err / dmem_rdata.
//
// Ports:
//   g_clk       in   global clock
//   g_reset     in   global reset, asynchronous, active-high
//   dmem_req    in   request valid, held until dmem_gnt
//   dmem_addr   in   64-bit byte address, word index = (addr-BASE_ADDR)>>3
//   dmem_wen    in   1 = write, 0 = read
//   dmem_strb   in   write byte strobes
//   dmem_wdata  in   write data
//   dmem_gnt    out  single-cycle response pulse
//   dmem_err    out  response error (with dmem_gnt)
//   dmem_rdata  out  read data (with dmem_gnt on reads)
//
// Option macro CROYDE_DMEM_ALIGN_CHECK_EN: when defined, non-naturally-aligned
// write strobes and misaligned read addresses complete with dmem_err=1.
module core_dmem_responder #(
   parameter int          MEM_DEPTH   = 1024,
   parameter logic [63:0] BASE_ADDR   = 64'h0,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        dmem_req,
   input  logic [63:0] dmem_addr,
   input  logic        dmem_wen,
   input  logic [7:0]  dmem_strb,
   input  logic [63:0] dmem_wdata,
   output logic        dmem_gnt,
   output logic        dmem_err,
   output logic [63:0] dmem_rdata
);
   localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
   localparam logic [63:0] SPAN = 64'(MEM_DEPTH) << 3;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   state_t state;
   logic [3:0] cnt;
   logic [AW-1:0] idx_q;
   logic wen_q, bad_q;
   logic [7:0] strb_q;
   logic [63:0] wdata_q;
   logic [63:0] mem [MEM_DEPTH];
   logic [63:0] off, resp_data;
   logic [AW-1:0] idx, sel_idx;
   logic bad, sel_bad, sel_wen;
`ifdef CROYDE_DMEM_ALIGN_CHECK_EN
   function automatic logic strb_ok(input logic [7:0] s);
      return s inside {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                       8'h03, 8'h0C, 8'h30, 8'hC0, 8'h0F, 8'hF0, 8'hFF};
   endfunction
`endif
   // Decode of the live request; in IDLE the accept edge may go straight to
   // RESP, so the response is formed from live fields there, latched otherwise.
   always_comb begin
      off = dmem_addr - BASE_ADDR;
      idx = off[AW+2:3];
      bad = (dmem_addr < BASE_ADDR) || (off >= SPAN);
`ifdef CROYDE_DMEM_ALIGN_CHECK_EN
      bad = bad || (dmem_wen ? !strb_ok(dmem_strb) : (dmem_addr[2:0] != 3'd0));
`endif
      sel_idx = state == S_IDLE ? idx : idx_q;
      sel_bad = state == S_IDLE ? bad : bad_q;
      sel_wen = state == S_IDLE ? dmem_wen : wen_q;
      resp_data = (sel_bad || sel_wen) ? 64'd0 : mem[sel_idx];
   end
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state <= S_IDLE;
         cnt <= '0;
         dmem_gnt <= 1'b0;
         dmem_err <= 1'b0;
         dmem_rdata <= '0;
         idx_q <= '0;
         wen_q <= 1'b0;
         bad_q <= 1'b0;
         strb_q <= '0;
         wdata_q <= '0;
      end else begin
         case (state)
            S_IDLE: if (dmem_req) begin
               idx_q <= idx;
               wen_q <= dmem_wen;
               bad_q <= bad;
               strb_q <= dmem_strb;
               wdata_q <= dmem_wdata;
               if (WAIT_CYCLES == 0) begin
                  state <= S_RESP;
                  dmem_gnt <= 1'b1;
                  dmem_err <= bad;
                  dmem_rdata <= resp_data;
               end else begin
                  state <= S_WAIT;
                  cnt <= 4'(WAIT_CYCLES);
               end
            end
            S_WAIT: if (!dmem_req) begin
               // pipeline flush: drop the request silently
               state <= S_IDLE;
               cnt <= '0;
            end else if (cnt == 4'd1) begin
               state <= S_RESP;
               cnt <= '0;
               dmem_gnt <= 1'b1;
               dmem_err <= bad_q;
               dmem_rdata <= resp_data;
            end else begin
               cnt <= cnt - 4'd1;
            end
            S_RESP: begin
               state <= S_IDLE;
               dmem_gnt <= 1'b0;
               dmem_err <= 1'b0;
               dmem_rdata <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
   // Write commits on the edge that ends the grant cycle; reset leaves RESP
   // immediately, so an interrupted write never lands.
   always_ff @(posedge g_clk) begin
      if (state == S_RESP && wen_q && !bad_q)
         for (int b = 0; b < 8; b++)
            if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
   end
endmodule
